// File: rtl/heap_pkg.sv
// Shared types and constants for the pipelined heap: FSM states, data width,
// the flush sentinel and the default sift-down spacing.
package heap_pkg;

   localparam int unsigned DATA_W         = 32;
   localparam int unsigned GAP_CYCLES_DEF = 8;

   // Largest unsigned word, so a flushed slot always sinks to the bottom
   localparam logic [DATA_W-1:0] SENTINEL_DEF = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_ACTIVE,
      ST_READ,
      ST_EMIT,
      ST_WRITE,
      ST_GAP
   } heap_state_e;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module gap_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_zero;

   // Flag tracks the count so the controller never decodes the counter itself
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_zero <= 1'b1;
      end else if (i_load) begin
         r_cnt  <= i_load_val;
         r_zero <= (i_load_val == '0);
      end else if (i_dec && !r_zero) begin
         r_cnt  <= r_cnt - CNT_W'(1);
         r_zero <= (r_cnt == CNT_W'(1));
      end
   end

   assign o_zero = r_zero;

endmodule

// File: rtl/heap_root_ctrl.sv
// Root-side replace-top controller: pops the root to a stream, writes the new
// value and launches level-1 sift-down. Define HEAP_SENTINEL_DROP_EN to suppress emitting popped sentinels.
module heap_root_ctrl
   import heap_pkg::*;
#(
   parameter int unsigned        GAP_CYCLES = GAP_CYCLES_DEF,
   parameter logic [DATA_W-1:0]  SENTINEL   = SENTINEL_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              flush,
   input  logic              stop,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   input  logic [DATA_W-1:0] root_q,
   output logic [DATA_W-1:0] root_data,
   output logic              root_wren,
   output logic              initialize,
   output logic              update_out,
   output logic              address_updated_out
);

   localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1);

   heap_state_e       r_state, w_next;
   logic              w_take_word, w_take_flush, w_gap_zero;
   logic              r_busy, r_s_ready, r_m_valid, r_root_wren, r_update, r_initialize;
   logic              r_stop_pend;
   logic [DATA_W-1:0] r_new_val, r_m_data, r_root_data;

   // Counter is loaded as WRITE is entered and counts through WRITE, so the
   // next accept lands GAP_CYCLES cycles after the update_out pulse
   gap_timer #(.CNT_W(CNT_W)) u_gap_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_next == ST_WRITE),
      .i_load_val (CNT_W'(GAP_CYCLES - 1)),
      .i_dec      ((r_state == ST_WRITE) || (r_state == ST_GAP)),
      .o_zero     (w_gap_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_take_word  = 1'b0;
      w_take_flush = 1'b0;
      case (r_state)
         ST_IDLE:   if (start) w_next = ST_INIT;
         ST_INIT:   w_next = ST_ACTIVE;
         ST_ACTIVE: begin
            if (s_valid) begin
               w_next      = ST_READ;
               w_take_word = 1'b1;
            end else if (flush) begin
               w_next       = ST_READ;
               w_take_flush = 1'b1;
            end else if (stop || r_stop_pend) begin
               w_next = ST_IDLE;
            end
         end
`ifdef HEAP_SENTINEL_DROP_EN
         ST_READ:   w_next = (root_q == SENTINEL) ? ST_WRITE : ST_EMIT;
`else
         ST_READ:   w_next = ST_EMIT;
`endif
         ST_EMIT:   if (m_ready) w_next = ST_WRITE;
         ST_WRITE:  w_next = ST_GAP;
         ST_GAP:    if (w_gap_zero) w_next = ST_ACTIVE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with the state itself
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy       <= 1'b0;
         r_s_ready    <= 1'b0;
         r_m_valid    <= 1'b0;
         r_root_wren  <= 1'b0;
         r_update     <= 1'b0;
         r_initialize <= 1'b0;
         r_stop_pend  <= 1'b0;
         r_new_val    <= '0;
         r_m_data     <= '0;
         r_root_data  <= '0;
      end else begin
         r_busy       <= (w_next != ST_IDLE);
         r_s_ready    <= (w_next == ST_ACTIVE);
         r_m_valid    <= (w_next == ST_EMIT);
         r_root_wren  <= (w_next == ST_WRITE);
         r_update     <= (w_next == ST_WRITE);
         r_initialize <= (r_state == ST_INIT);
         if (r_state == ST_IDLE) r_stop_pend <= 1'b0;
         else if (stop)          r_stop_pend <= 1'b1;
         if (w_take_word)        r_new_val <= s_data;
         else if (w_take_flush)  r_new_val <= SENTINEL;
         if (r_state == ST_READ) r_m_data <= root_q;
         if (w_next == ST_WRITE) r_root_data <= r_new_val;
      end
   end

   assign busy                = r_busy;
   assign s_ready             = r_s_ready;
   assign m_valid             = r_m_valid;
   assign m_data              = r_m_data;
   assign root_data           = r_root_data;
   assign root_wren           = r_root_wren;
   assign initialize          = r_initialize;
   assign update_out          = r_update;
   assign address_updated_out = 1'b0;

endmodule

// File: tb/tb_heap_root_ctrl.sv
// Bench for heap_root_ctrl: event-time model of the replace-top protocol checked
// every cycle, plus literal expectations along the directed sequence.
module tb_heap_root_ctrl;

   localparam int unsigned GAP  = 8;
   localparam logic [31:0] SENT = 32'hFFFF_FFFF;
`ifdef HEAP_SENTINEL_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, start, s_valid, flush, stop, m_ready;
   logic [31:0] s_data;
   logic        busy, s_ready, m_valid, root_wren, initialize, update_out, address_updated_out;
   logic [31:0] m_data, root_data, root_q;

   heap_root_ctrl #(.GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .flush(flush), .stop(stop),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .root_q(root_q), .root_data(root_data), .root_wren(root_wren),
      .initialize(initialize), .update_out(update_out),
      .address_updated_out(address_updated_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Root RAM: one word, registered read, optional preload from the stimulus
   logic [31:0] ram_word = 32'd0;
   logic        pre_en   = 1'b0;
   logic [31:0] pre_val  = 32'd0;
   always @(posedge clk) begin
      root_q <= ram_word;
      if (root_wren)   ram_word <= root_data;
      else if (pre_en) ram_word <= pre_val;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Model: session flag, operation timestamps and the root value it expects
   bit          mdl_on = 1'b0;
   bit          sess = 1'b0, op = 1'b0, drop = 1'b0, spend = 1'b0, took_stop;
   bit          md_zero = 1'b1, rd_zero = 1'b1;
   int          n, acc = 0, ready_at = 0, init_at = -1, write_at = -1;
   logic [31:0] mroot = 32'd0, nv = 32'd0, pop = 32'd0;
   bit          e_rdy, e_mv, e_wr;

   always @(negedge clk) begin
      if (mdl_on) begin
         n     = cyc;
         e_rdy = sess && !op && (n >= ready_at);
         e_mv  = op && !drop && (n >= acc + 2) && (write_at < 0);
         e_wr  = op && (n == write_at);
         chk("busy",       32'(busy),       32'(sess));
         chk("s_ready",    32'(s_ready),    32'(e_rdy));
         chk("m_valid",    32'(m_valid),    32'(e_mv));
         chk("root_wren",  32'(root_wren),  32'(e_wr));
         chk("update_out", 32'(update_out), 32'(e_wr));
         chk("initialize", 32'(initialize), 32'(n == init_at));
         chk("addr_upd",   32'(address_updated_out), 32'd0);
         if (e_mv)         chk("m_data", m_data, pop);
         else if (md_zero) chk("m_data_rst", m_data, 32'd0);
         if (e_wr)         chk("root_data", root_data, nv);
         else if (rd_zero) chk("root_data_rst", root_data, 32'd0);
         if (rst) begin
            sess = 0; op = 0; spend = 0; init_at = -1; write_at = -1;
            md_zero = 1; rd_zero = 1;
         end else begin
            if (pre_en) mroot = pre_val;
            if (e_wr) begin
               mroot = nv; op = 0; write_at = -1; ready_at = n + GAP; rd_zero = 0;
            end
            if (e_mv && m_ready) write_at = n + 1;
            if (!sess) begin
               if (start) begin sess = 1; init_at = n + 2; ready_at = n + 2; end
            end else begin
               took_stop = 0;
               if (e_rdy && (s_valid || flush)) begin
                  op = 1; acc = n; nv = s_valid ? s_data : SENT; pop = mroot;
                  drop = DROP_EN && (mroot == SENT); md_zero = 0;
                  if (drop) write_at = n + 2;
               end else if (e_rdy && (stop || spend)) begin
                  sess = 0; spend = 0; took_stop = 1;
               end
               if (stop && !took_stop) spend = 1;
            end
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic go(input int c); while (cyc < c) tick(); endtask
   task automatic preload(input logic [31:0] v);
      pre_en = 1'b1; pre_val = v; tick(); pre_en = 1'b0;
   endtask
   task automatic wait_ready();
      int k = 0;
      while (s_ready !== 1'b1 && k < 64) begin tick(); k++; end
      if (s_ready !== 1'b1) chk("wait_ready", 32'(s_ready), 32'd1);
   endtask

   int t;

   initial begin
      rst = 1; start = 0; s_valid = 0; flush = 0; stop = 0; m_ready = 0; s_data = '0;
      repeat (3) tick();
      rst = 0; mdl_on = 1'b1;
      @(negedge clk);
      chk("L_rst_busy", 32'(busy), 32'd0);
      chk("L_rst_sready", 32'(s_ready), 32'd0);
      chk("L_rst_mvalid", 32'(m_valid), 32'd0);
      chk("L_rst_init", 32'(initialize), 32'd0);
      chk("L_rst_mdata", m_data, 32'd0);
      chk("L_rst_rdata", root_data, 32'd0);

      // Session start: initialize two cycles after start
      tick(); t = cyc; start = 1; tick(); start = 0;
      @(negedge clk); chk("L_busy_t1", 32'(busy), 32'd1); chk("L_init_t1", 32'(initialize), 32'd0);
      go(t + 2); @(negedge clk); chk("L_init_t2", 32'(initialize), 32'd1);
      go(t + 3); @(negedge clk); chk("L_init_t3", 32'(initialize), 32'd0);
      go(t + 4); start = 1; tick(); start = 0;

      // Root 5, insert 9, m_ready high
      wait_ready(); preload(32'd5);
      t = cyc; s_valid = 1; s_data = 32'd9; m_ready = 1; tick(); s_valid = 0;
      go(t + 2); @(negedge clk);
      chk("L_A_mvalid", 32'(m_valid), 32'd1); chk("L_A_mdata", m_data, 32'd5);
      go(t + 3); @(negedge clk);
      chk("L_A_wren", 32'(root_wren), 32'd1); chk("L_A_rdata", root_data, 32'd9);
      chk("L_A_upd", 32'(update_out), 32'd1);
      go(t + 2 + GAP); @(negedge clk); chk("L_A_gap", 32'(s_ready), 32'd0);
      go(t + 3 + GAP); @(negedge clk); chk("L_A_ready", 32'(s_ready), 32'd1);

      // Back-pressure for 10 cycles
      go(t + 4 + GAP); wait_ready();
      t = cyc; s_valid = 1; s_data = 32'd4; m_ready = 0; tick(); s_valid = 0;
      go(t + 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("L_B_mvalid", 32'(m_valid), 32'd1); chk("L_B_mdata", m_data, 32'd9);
         chk("L_B_nowr", 32'(root_wren), 32'd0);
         tick();
      end
      m_ready = 1;
      @(negedge clk); chk("L_B_wr0", 32'(root_wren), 32'd0);
      tick(); @(negedge clk);
      chk("L_B_wr1", 32'(root_wren), 32'd1); chk("L_B_rdata", root_data, 32'd4);

      // Flush over root 7
      tick(); wait_ready(); preload(32'd7);
      t = cyc; flush = 1; tick(); flush = 0;
      go(t + 2); @(negedge clk); chk("L_C_mdata", m_data, 32'd7);
      go(t + 3); @(negedge clk); chk("L_C_rdata", root_data, SENT);

      // Flush over a sentinel root
      tick(); wait_ready();
      t = cyc; flush = 1; tick(); flush = 0;
      go(t + 2); @(negedge clk);
      if (DROP_EN) begin
         chk("L_D_nomv", 32'(m_valid), 32'd0); chk("L_D_wren", 32'(root_wren), 32'd1);
      end else begin
         chk("L_D_mvalid", 32'(m_valid), 32'd1); chk("L_D_mdata", m_data, SENT);
      end

      // s_valid beats flush
      tick(); wait_ready(); preload(32'd7);
      t = cyc; s_valid = 1; flush = 1; s_data = 32'd3; tick(); s_valid = 0; flush = 0;
      go(t + 3); @(negedge clk);
      chk("L_E_wren", 32'(root_wren), 32'd1); chk("L_E_rdata", root_data, 32'd3);

      // Stop during the gap is held until the next ACTIVE
      go(t + 5); stop = 1; tick(); stop = 0;
      go(t + 4 + GAP); @(negedge clk); chk("L_stop_busy", 32'(busy), 32'd0);

      // Reset while emitting
      tick(); start = 1; tick(); start = 0;
      wait_ready();
      t = cyc; s_valid = 1; s_data = 32'h11; m_ready = 0; tick(); s_valid = 0;
      go(t + 2); rst = 1; m_ready = 1;
      @(negedge clk); chk("L_R_mvalid", 32'(m_valid), 32'd1); chk("L_R_mdata", m_data, 32'd3);
      tick(); rst = 0; s_valid = 1;
      @(negedge clk);
      chk("L_R_mv0", 32'(m_valid), 32'd0); chk("L_R_busy0", 32'(busy), 32'd0);
      chk("L_R_md0", m_data, 32'd0); chk("L_R_wr0", 32'(root_wren), 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick(); @(negedge clk);
         chk("L_R_noupd", 32'(update_out), 32'd0);
      end
      s_valid = 0;
      repeat (3) tick();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
